// File: rtl/mod_inv_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod_inv_seq_pkg
//  Description : Shared field constants, FSM encoding and Montgomery
//                reduction helper for the Z_q (q = 3329) modular inverter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mod_inv_seq_pkg;

  localparam int DATA_W = 12;
  localparam int EXP_W  = 12;

  localparam logic [DATA_W-1:0] Q      = 12'd3329;
  // -q^-1 mod 2^12
  localparam logic [DATA_W-1:0] QINV   = 12'd3327;
  localparam logic [DATA_W-1:0] R_MOD  = 12'd767;
  localparam logic [DATA_W-1:0] R2_MOD = 12'd2385;
  localparam logic [EXP_W-1:0]  EXP    = 12'd3327;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TOMONT   = 3'd1,
    ST_SQR      = 3'd2,
    ST_MUL      = 3'd3,
    ST_FROMMONT = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // REDC(t) = t * R^-1 mod q, valid for t < q*R; result in [0, q)
  function automatic logic [DATA_W-1:0] mont_redc(input logic [2*DATA_W-1:0] t);
    logic [DATA_W-1:0]   m;
    logic [2*DATA_W:0]   s;
    logic [DATA_W:0]     u;
    logic [DATA_W:0]     d;
    m = t[DATA_W-1:0] * QINV;
    s = {1'b0, t} + (2*DATA_W+1)'(m) * (2*DATA_W+1)'(Q);
    u = s[2*DATA_W:DATA_W];
    d = u - {1'b0, Q};
    return (u >= {1'b0, Q}) ? d[DATA_W-1:0] : u[DATA_W-1:0];
  endfunction

endpackage : mod_inv_seq_pkg
`default_nettype wire

// File: rtl/mod_inv_seq_mult_rd.sv
`default_nettype none
// ============================================================================
//  Module      : mod_inv_seq_mult_rd
//  Description : Two-cycle Montgomery product p = a*b*R^-1 mod q. The raw
//                product is registered; reduction is combinational on it.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_inv_seq_mult_rd
  import mod_inv_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] p
);

  logic [2*DATA_W-1:0] r_prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prod <= '0;
    end else if (en) begin
      r_prod <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
    end
  end

  assign p = mont_redc(r_prod);

endmodule : mod_inv_seq_mult_rd
`default_nettype wire

// File: rtl/mod_inv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mod_inv_seq
//  Description : Sequential Fermat inverter over Z_3329 (dout = din^(q-2)),
//                square-and-multiply on one shared Montgomery multiplier.
//                Optional macro MOD_INV_ZERO_BYPASS_EN: zero operand skips
//                the exponentiation and reports err two cycles after accept.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_inv_seq
  import mod_inv_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic              err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ph;
  logic [3:0]        r_bit;
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_xm;
  logic [DATA_W-1:0] r_acc;
  logic              r_err;
  logic [DATA_W-1:0] r_dout;
  logic              r_err_o;
  logic              r_out_valid;

  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_prod;
  logic [DATA_W-1:0] w_x_red;
  logic              w_accept;
  logic              w_cap;
  logic              w_bit_dec;
  logic              w_compute;
  logic              w_bypass;

`ifdef MOD_INV_ZERO_BYPASS_EN
  assign w_bypass = r_err;
`else
  assign w_bypass = 1'b0;
`endif

  assign in_ready  = (r_state == ST_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_x_red   = (din >= Q) ? din - Q : din;
  assign w_compute = (r_state == ST_TOMONT) || (r_state == ST_SQR) ||
                     (r_state == ST_MUL)    || (r_state == ST_FROMMONT);

  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign err       = r_err_o;

  mod_inv_seq_mult_rd u_mult (
    .clk (clk),
    .rst (rst),
    .en  (w_compute),
    .a   (w_op_a),
    .b   (w_op_b),
    .p   (w_prod)
  );

  // Each product holds its operands for two cycles (r_ph 0,1); the result
  // is captured on the edge that ends the r_ph=1 cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_op_a      = r_acc;
    w_op_b      = r_acc;
    w_cap       = 1'b0;
    w_bit_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_TOMONT;
      end
      ST_TOMONT: begin
        w_op_a = r_x;
        w_op_b = R2_MOD;
        if (w_bypass) begin
          w_state_nxt = ST_DONE;
        end else if (r_ph) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_SQR;
        end
      end
      ST_SQR: begin
        if (r_ph) begin
          w_cap = 1'b1;
          if (EXP[r_bit]) begin
            w_state_nxt = ST_MUL;
          end else if (r_bit == 4'd0) begin
            w_state_nxt = ST_FROMMONT;
          end else begin
            w_bit_dec   = 1'b1;
            w_state_nxt = ST_SQR;
          end
        end
      end
      ST_MUL: begin
        w_op_b = r_xm;
        if (r_ph) begin
          w_cap = 1'b1;
          if (r_bit == 4'd0) begin
            w_state_nxt = ST_FROMMONT;
          end else begin
            w_bit_dec   = 1'b1;
            w_state_nxt = ST_SQR;
          end
        end
      end
      ST_FROMMONT: begin
        w_op_b = {{(DATA_W-1){1'b0}}, 1'b1};
        if (r_ph) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (r_out_valid && out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ph        <= 1'b0;
      r_bit       <= '0;
      r_x         <= '0;
      r_xm        <= '0;
      r_acc       <= '0;
      r_err       <= 1'b0;
      r_dout      <= '0;
      r_err_o     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ph    <= w_compute ? ~r_ph : 1'b0;

      if (w_accept) begin
        r_x   <= w_x_red;
        r_err <= (w_x_red == '0);
        r_acc <= R_MOD;
        r_bit <= 4'(EXP_W - 1);
      end

      if (w_cap) begin
        if (r_state == ST_TOMONT) r_xm  <= w_prod;
        else                      r_acc <= w_prod;
      end

      if (w_bit_dec) r_bit <= r_bit - 4'd1;

      // Result register loads on the first DONE cycle, then holds until taken
      if (r_state == ST_DONE) begin
        if (!r_out_valid) begin
          r_out_valid <= 1'b1;
          r_dout      <= r_err ? '0 : r_acc;
          r_err_o     <= r_err;
        end else if (out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

endmodule : mod_inv_seq
`default_nettype wire
